// File: rtl/ahb3lite_apb_bridge.sv
// ============================================================================
// Module      : ahb3lite_apb_bridge
// Description : AHB3-Lite slave to APB master bridge on a single clock.
//               Each AHB transfer becomes one APB SETUP/ACCESS pair. Writes
//               spend one extra cycle capturing HWDATA. Oversized transfers
//               and APB slave errors produce a two-cycle AHB ERROR response.
//               Every output is driven straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb3lite_apb_bridge #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 8,
    parameter int PDATA_SIZE = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    // AHB3-Lite slave side
    input  logic                    HSEL,
    input  logic [HADDR_SIZE-1:0]   HADDR,
    input  logic [HDATA_SIZE-1:0]   HWDATA,
    output logic [HDATA_SIZE-1:0]   HRDATA,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic [1:0]              HTRANS,
    input  logic                    HMASTLOCK,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    // APB master side
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [2:0]              PPROT,
    output logic                    PWRITE,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int         c_STRB_W    = PDATA_SIZE / 8;
    localparam int         c_LANE_W    = (c_STRB_W > 1) ? $clog2(c_STRB_W) : 1;
    localparam logic [2:0] c_MAX_HSIZE = 3'($clog2(HDATA_SIZE / 8));

    // Bridge state encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_WDATA  = 3'd1;
    localparam logic [2:0] c_ST_SETUP  = 3'd2;
    localparam logic [2:0] c_ST_ACCESS = 3'd3;
    localparam logic [2:0] c_ST_ERR1   = 3'd4;
    localparam logic [2:0] c_ST_ERR2   = 3'd5;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic                    w_accept;
    logic                    w_size_err;
    logic [c_STRB_W-1:0]     w_strb;
    int                      w_offset;

    logic                    r_hreadyout;
    logic                    r_hresp;
    logic [HDATA_SIZE-1:0]   r_hrdata;
    logic                    r_psel;
    logic                    r_penable;
    logic [2:0]              r_pprot;
    logic                    r_pwrite;
    logic [c_STRB_W-1:0]     r_pstrb;
    logic [PADDR_SIZE-1:0]   r_paddr;
    logic [PDATA_SIZE-1:0]   r_pwdata;

    logic                    w_hreadyout_nxt;
    logic                    w_hresp_nxt;
    logic                    w_psel_nxt;
    logic                    w_penable_nxt;

    // Inputs that carry no meaning for an APB target are folded away here
    logic                    w_unused;
    assign w_unused = ^{HADDR, HBURST, HMASTLOCK, HPROT[3:2], HTRANS[0]};

    // A new address phase is only taken while the bridge is free
    assign w_accept   = ((r_state == c_ST_IDLE) || (r_state == c_ST_ERR2)) &&
                        HSEL && HREADY && HTRANS[1];
    assign w_size_err = (HSIZE > c_MAX_HSIZE);

    // Byte lanes covered by the naturally aligned block of size 2^HSIZE
    always_comb begin
        w_strb   = '0;
        w_offset = int'(HADDR[c_LANE_W-1:0]);
        for (int i = 0; i < c_STRB_W; i++) begin
            w_strb[i] = ((i >> HSIZE) == (w_offset >> HSIZE));
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_ERR2: begin
                if (w_accept) begin
                    if (w_size_err) begin
                        w_state_nxt = c_ST_ERR1;
                    end else if (HWRITE) begin
                        w_state_nxt = c_ST_WDATA;
                    end else begin
                        w_state_nxt = c_ST_SETUP;
                    end
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WDATA:  w_state_nxt = c_ST_SETUP;
            c_ST_SETUP:  w_state_nxt = c_ST_ACCESS;
            c_ST_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt = PSLVERR ? c_ST_ERR1 : c_ST_IDLE;
                end
            end
            c_ST_ERR1:   w_state_nxt = c_ST_ERR2;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Handshake outputs are a pure decode of the state being entered
    always_comb begin
        w_hreadyout_nxt = (w_state_nxt == c_ST_IDLE) || (w_state_nxt == c_ST_ERR2);
        w_hresp_nxt     = (w_state_nxt == c_ST_ERR1) || (w_state_nxt == c_ST_ERR2);
        w_psel_nxt      = (w_state_nxt == c_ST_SETUP) || (w_state_nxt == c_ST_ACCESS);
        w_penable_nxt   = (w_state_nxt == c_ST_ACCESS);
    end

    // State and handshake output registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= c_ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hreadyout <= w_hreadyout_nxt;
            r_hresp     <= w_hresp_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
        end
    end

    // Address-phase attributes captured once per accepted transfer, so they
    // hold steady through SETUP and every ACCESS wait cycle
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pprot  <= 3'b000;
            r_pstrb  <= '0;
        end else if (w_accept) begin
            r_paddr  <= HADDR[PADDR_SIZE-1:0];
            r_pwrite <= HWRITE;
            r_pprot  <= {~HPROT[0], 1'b0, HPROT[1]};
            r_pstrb  <= HWRITE ? w_strb : '0;
        end
    end

    // Write data is taken in the AHB data phase, which is the WDATA cycle
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pwdata <= '0;
        end else if (r_state == c_ST_WDATA) begin
            r_pwdata <= HWDATA;
        end
    end

    // Read data is captured only on a successful APB read completion
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hrdata <= '0;
        end else if ((r_state == c_ST_ACCESS) && PREADY && !PSLVERR && !r_pwrite) begin
            r_hrdata <= PRDATA;
        end
    end

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign HRDATA    = r_hrdata;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PPROT     = r_pprot;
    assign PWRITE    = r_pwrite;
    assign PSTRB     = r_pstrb;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb3lite_apb_bridge.sv
// ============================================================================
// Module      : tb_ahb3lite_apb_bridge
// Description : Directed self-checking bench for ahb3lite_apb_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb3lite_apb_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic        PSEL;
    logic        PENABLE;
    logic [2:0]  PPROT;
    logic        PWRITE;
    logic [3:0]  PSTRB;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int vectors    = 0;
    int miscompares = 0;

    // Single-slave system: the bus ready is the slave's own ready
    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb3lite_apb_bridge #(
        .HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(8), .PDATA_SIZE(32)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PSEL(PSEL),
        .PENABLE(PENABLE), .PPROT(PPROT), .PWRITE(PWRITE), .PSTRB(PSTRB),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
        HSIZE = 3'b010; HBURST = 3'b000; HPROT = 4'b0011; HTRANS = 2'b00;
        HMASTLOCK = 1'b0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        tick(); tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0010) begin
            miscompares++;
            $display("FAIL reset_ctl got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0010);
        end
        vectors++;
        if ({HRDATA, PWRITE, PSTRB, PPROT, PADDR, PWDATA} !== 80'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h exp %h", {HRDATA, PWRITE, PSTRB, PPROT, PADDR, PWDATA}, 80'h0);
        end
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_read();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0014; HWRITE = 1'b0;
        HSIZE = 3'b010; HPROT = 4'b0011; PREADY = 1'b1; PRDATA = 32'hDEADBEEF;
        tick();
        HTRANS = 2'b00;
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b1000) begin
            miscompares++;
            $display("FAIL rd_setup_ctl got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b1000);
        end
        vectors++;
        if ({PADDR, PSTRB, PWRITE, PPROT} !== {8'h14, 4'h0, 1'b0, 3'b001}) begin
            miscompares++;
            $display("FAIL rd_setup_attr got %h exp %h", {PADDR, PSTRB, PWRITE, PPROT}, {8'h14, 4'h0, 1'b0, 3'b001});
        end
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP, PADDR} !== {4'b1100, 8'h14}) begin
            miscompares++;
            $display("FAIL rd_access got %h exp %h", {PSEL, PENABLE, HREADYOUT, HRESP, PADDR}, {4'b1100, 8'h14});
        end
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0010) begin
            miscompares++;
            $display("FAIL rd_done_ctl got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0010);
        end
        vectors++;
        if (HRDATA !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd_data got %h exp %h", HRDATA, 32'hDEADBEEF);
        end
    endtask

    task automatic test_byte_write();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h1000_0003; HWRITE = 1'b1;
        HSIZE = 3'b000; HPROT = 4'b0011; PREADY = 1'b1; PRDATA = 32'h0BADF00D;
        tick();
        HTRANS = 2'b00; HWDATA = 32'hAA00_0000;
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0000) begin
            miscompares++;
            $display("FAIL wr_wdata_ctl got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0000);
        end
        tick();
        HWDATA = 32'h0;
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b1000) begin
            miscompares++;
            $display("FAIL wr_setup_ctl got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b1000);
        end
        vectors++;
        if ({PADDR, PSTRB, PWRITE, PWDATA} !== {8'h03, 4'b1000, 1'b1, 32'hAA00_0000}) begin
            miscompares++;
            $display("FAIL wr_setup_attr got %h exp %h", {PADDR, PSTRB, PWRITE, PWDATA}, {8'h03, 4'b1000, 1'b1, 32'hAA00_0000});
        end
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP, PSTRB, PWDATA} !== {4'b1100, 4'b1000, 32'hAA00_0000}) begin
            miscompares++;
            $display("FAIL wr_access got %h exp %h", {PSEL, PENABLE, HREADYOUT, HRESP, PSTRB, PWDATA}, {4'b1100, 4'b1000, 32'hAA00_0000});
        end
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0010) begin
            miscompares++;
            $display("FAIL wr_done_ctl got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0010);
        end
        vectors++;
        if (HRDATA !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_keeps_hrdata got %h exp %h", HRDATA, 32'hDEADBEEF);
        end
    endtask

    task automatic test_read_wait();
        int lows;
        lows = 0;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0030; HWRITE = 1'b0;
        HSIZE = 3'b010; HPROT = 4'b0011; PREADY = 1'b0; PRDATA = 32'hCAFE_0001;
        tick();
        HTRANS = 2'b00;
        if (!HREADYOUT) lows++;
        tick();
        if (!HREADYOUT) lows++;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (!HREADYOUT) lows++;
            vectors++;
            if ({PSEL, PENABLE, HREADYOUT, PADDR, PSTRB, PWRITE} !== {3'b110, 8'h30, 4'h0, 1'b0}) begin
                miscompares++;
                $display("FAIL rdw_stall%0d got %h exp %h", k, {PSEL, PENABLE, HREADYOUT, PADDR, PSTRB, PWRITE}, {3'b110, 8'h30, 4'h0, 1'b0});
            end
        end
        PREADY = 1'b1;
        tick();
        vectors++;
        if (lows !== 5) begin
            miscompares++;
            $display("FAIL rdw_wait_states got %0d exp %0d", lows, 5);
        end
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP, HRDATA} !== {4'b0010, 32'hCAFE_0001}) begin
            miscompares++;
            $display("FAIL rdw_done got %h exp %h", {PSEL, PENABLE, HREADYOUT, HRESP, HRDATA}, {4'b0010, 32'hCAFE_0001});
        end
    endtask

    task automatic test_write_slverr();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0022; HWRITE = 1'b1;
        HSIZE = 3'b001; HPROT = 4'b0010; PREADY = 1'b1; PSLVERR = 1'b1;
        tick();
        HTRANS = 2'b00; HWDATA = 32'h5A5A_1234;
        tick();
        vectors++;
        if ({PADDR, PSTRB, PPROT, PWRITE} !== {8'h22, 4'b1100, 3'b101, 1'b1}) begin
            miscompares++;
            $display("FAIL err_setup_attr got %h exp %h", {PADDR, PSTRB, PPROT, PWRITE}, {8'h22, 4'b1100, 3'b101, 1'b1});
        end
        tick();
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0001) begin
            miscompares++;
            $display("FAIL err_first got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0001);
        end
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0011) begin
            miscompares++;
            $display("FAIL err_second got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0011);
        end
        tick();
        PSLVERR = 1'b0;
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0010) begin
            miscompares++;
            $display("FAIL err_idle got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0010);
        end
    endtask

    task automatic test_size_err_busy();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0008; HWRITE = 1'b0;
        HSIZE = 3'b011; HPROT = 4'b0011;
        tick();
        HTRANS = 2'b00; HSIZE = 3'b010;
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0001) begin
            miscompares++;
            $display("FAIL size_err1 got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0001);
        end
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0011) begin
            miscompares++;
            $display("FAIL size_err2 got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0011);
        end
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0010) begin
            miscompares++;
            $display("FAIL size_idle got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0010);
        end
        HTRANS = 2'b01; HADDR = 32'h0000_0010;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0010) begin
                miscompares++;
                $display("FAIL busy%0d got %b exp %b", k, {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0010);
            end
        end
        HTRANS = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0040; HWRITE = 1'b0;
        HSIZE = 3'b010; HPROT = 4'b0011; PREADY = 1'b1; PRDATA = 32'h1111_1111;
        tick();
        HADDR = 32'h0000_0044;
        tick();
        tick();
        PRDATA = 32'h2222_2222;
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRDATA} !== {3'b001, 32'h1111_1111}) begin
            miscompares++;
            $display("FAIL b2b_first got %h exp %h", {PSEL, PENABLE, HREADYOUT, HRDATA}, {3'b001, 32'h1111_1111});
        end
        tick();
        HTRANS = 2'b00;
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, PADDR} !== {3'b100, 8'h44}) begin
            miscompares++;
            $display("FAIL b2b_second_setup got %h exp %h", {PSEL, PENABLE, HREADYOUT, PADDR}, {3'b100, 8'h44});
        end
        tick();
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRDATA} !== {3'b001, 32'h2222_2222}) begin
            miscompares++;
            $display("FAIL b2b_second_done got %h exp %h", {PSEL, PENABLE, HREADYOUT, HRDATA}, {3'b001, 32'h2222_2222});
        end
    endtask

    task automatic test_reset_in_access();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0055; HWRITE = 1'b0;
        HSIZE = 3'b010; HPROT = 4'b0011; PREADY = 1'b0;
        tick();
        HTRANS = 2'b00;
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT} !== 3'b110) begin
            miscompares++;
            $display("FAIL rst_pre_access got %b exp %b", {PSEL, PENABLE, HREADYOUT}, 3'b110);
        end
        HRESET = 1'b1;
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0010) begin
            miscompares++;
            $display("FAIL rst_abort_ctl got %b exp %b", {PSEL, PENABLE, HREADYOUT, HRESP}, 4'b0010);
        end
        vectors++;
        if ({HRDATA, PWRITE, PSTRB, PPROT, PADDR, PWDATA} !== 80'h0) begin
            miscompares++;
            $display("FAIL rst_abort_data got %h exp %h", {HRDATA, PWRITE, PSTRB, PPROT, PADDR, PWDATA}, 80'h0);
        end
        HRESET = 1'b0; PREADY = 1'b1;
        tick();
        HTRANS = 2'b10; HADDR = 32'h0000_0014; PRDATA = 32'h1234_5678;
        tick();
        HTRANS = 2'b00;
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, PADDR} !== {3'b100, 8'h14}) begin
            miscompares++;
            $display("FAIL rst_new_setup got %h exp %h", {PSEL, PENABLE, HREADYOUT, PADDR}, {3'b100, 8'h14});
        end
        tick();
        tick();
        vectors++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP, HRDATA} !== {4'b0010, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL rst_new_done got %h exp %h", {PSEL, PENABLE, HREADYOUT, HRESP, HRDATA}, {4'b0010, 32'h1234_5678});
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_read_wait();
        test_write_slverr();
        test_size_err_busy();
        test_back_to_back();
        test_reset_in_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
